// File: rtl/serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_borrow_subtractor
// Description : Bit-serial ripple-borrow subtractor, LSB first, computing
//               diff = a - b - bin (mod 2^WIDTH) with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic w_accept;
    logic w_last;
    logic w_d;
    logic w_br_next;

    // Operands are shifted right, so the current bit always sits at index 0.
    assign w_accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_last    = (cnt_q == CNT_LAST);
    assign w_d       = a_q[0] ^ b_q[0] ^ br_q;
    assign w_br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (w_last) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (w_accept) begin
            a_d    = a;
            b_d    = b;
            br_d   = bin;
            cnt_d  = '0;
            diff_d = '0;
            bout_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            a_d    = {1'b0, a_q[WIDTH-1:1]};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            br_d   = w_br_next;
            cnt_d  = cnt_q + CW'(1);
            diff_d = {w_d, diff_q[WIDTH-1:1]};
            if (w_last) bout_d = w_br_next;
        end
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_borrow_subtractor
// Description : Directed self-checking bench for serial_borrow_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_borrow_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_borrow_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle and waits (bounded) for done; lat is cycles from accept edge.
    task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                         output logic [3:0] od, output logic obo, output int lat);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        od  = diff;
        obo = bout;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, bout, diff} !== 7'b0)
            $display("FAIL reset_state: got busy=%b done=%b bout=%b diff=%0d, want all 0", busy, done, bout, diff);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL basic_busy%0d: got busy=%b done=%b, want 1 0", i, busy, done);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== 4'd6 || bout !== 1'b0)
            $display("FAIL basic_done: got done=%b busy=%b diff=%0d bout=%b, want 1 0 6 0", done, busy, diff, bout);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || diff !== 4'd6 || bout !== 1'b0)
            $display("FAIL basic_hold: got done=%b diff=%0d bout=%b, want 0 6 0", done, diff, bout);
        else pass_cnt++;
    endtask

    task automatic test_borrow();
        logic [3:0] d; logic bo; int lat;
        do_op(4'd3, 4'd9, 1'b0, d, bo, lat);
        total_cnt++;
        if (lat !== 5 || d !== 4'd10 || bo !== 1'b1)
            $display("FAIL borrow_3m9: got lat=%0d diff=%0d bout=%b, want 5 10 1", lat, d, bo);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        logic [3:0] d; logic bo; int lat;
        do_op(4'd0, 4'd0, 1'b1, d, bo, lat);
        total_cnt++;
        if (lat !== 5 || d !== 4'd15 || bo !== 1'b1)
            $display("FAIL edge_0m0b1: got lat=%0d diff=%0d bout=%b, want 5 15 1", lat, d, bo);
        else pass_cnt++;
        do_op(4'd15, 4'd15, 1'b0, d, bo, lat);
        total_cnt++;
        if (lat !== 5 || d !== 4'd0 || bo !== 1'b0)
            $display("FAIL edge_15m15: got lat=%0d diff=%0d bout=%b, want 5 0 0", lat, d, bo);
        else pass_cnt++;
        do_op(4'd6, 4'd6, 1'b1, d, bo, lat);
        total_cnt++;
        if (lat !== 5 || d !== 4'd15 || bo !== 1'b1)
            $display("FAIL edge_6m6b1: got lat=%0d diff=%0d bout=%b, want 5 15 1", lat, d, bo);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge clk);
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'd1;
        c = 1;
        while (!done && c < 20) begin @(negedge clk); c++; end
        total_cnt++;
        if (c !== 5 || diff !== 4'd6 || bout !== 1'b0)
            $display("FAIL b2b_first: got lat=%0d diff=%0d bout=%b, want 5 6 0", c, diff, bout);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_restart: got busy=%b done=%b, want 1 0", busy, done);
        else pass_cnt++;
        c = 1;
        while (!done && c < 20) begin @(negedge clk); c++; end
        start = 1'b0;
        total_cnt++;
        if (c !== 5 || diff !== 4'd14 || bout !== 1'b1)
            $display("FAIL b2b_second: got period=%0d diff=%0d bout=%b, want 5 14 1", c, diff, bout);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] d; logic bo; int lat;
        a = 4'd12; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, bout, diff} !== 7'b0)
            $display("FAIL midreset: got busy=%b done=%b bout=%b diff=%0d, want all 0", busy, done, bout, diff);
        else pass_cnt++;
        do_op(4'd12, 4'd5, 1'b0, d, bo, lat);
        total_cnt++;
        if (lat !== 5 || d !== 4'd7 || bo !== 1'b0)
            $display("FAIL midreset_fresh: got lat=%0d diff=%0d bout=%b, want 5 7 0", lat, d, bo);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [8:0] v;
        logic [4:0] m;
        int         c;
        int         done_cnt;
        done_cnt = 0;
        @(negedge clk);
        v = 9'd0;
        {a, b, bin} = v; start = 1'b1;
        for (int k = 0; k < 512; k++) begin
            c = 0;
            do begin @(negedge clk); c++; end while (!done && c < 20);
            if (!done) begin
                total_cnt++;
                $display("FAIL sweep_timeout: op %0d got no done within %0d cycles, want done", k, c);
                break;
            end
            done_cnt++;
            v = 9'(k);
            m = {1'b0, v[8:5]} - {1'b0, v[4:1]} - {4'b0, v[0]};
            total_cnt++;
            if (c !== 5 || {bout, diff} !== m)
                $display("FAIL sweep: a=%0d b=%0d bin=%b got period=%0d bout=%b diff=%0d, want 5 %b %0d",
                         v[8:5], v[4:1], v[0], c, bout, diff, m[4], m[3:0]);
            else pass_cnt++;
            if (k < 511) begin
                v = 9'(k + 1);
                {a, b, bin} = v;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        total_cnt++;
        if (done_cnt !== 512)
            $display("FAIL sweep_count: got %0d done pulses, want 512", done_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
